// File: rtl/br_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | br_pkg : shared types and helpers for the br_nport register bank  |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
package br_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    DUMP_IDLE = 2'd0,
    DUMP_SCAN = 2'd1,
    DUMP_DONE = 2'd2
  } dump_state_e;

  typedef enum logic [1:0] {
    SEL_MEM    = 2'd0,
    SEL_ZERO   = 2'd1,
    SEL_BYPASS = 2'd2
  } rd_sel_e;

  function automatic int addr_width(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

  // Zero register wins over bypass; wr_hit must already exclude discarded writes.
  function automatic rd_sel_e rd_select(input logic zero_en, input logic bypass_en,
                                        input logic addr_zero, input logic wr_hit);
    if (zero_en && addr_zero) return SEL_ZERO;
    if (bypass_en && wr_hit) return SEL_BYPASS;
    return SEL_MEM;
  endfunction

endpackage
`default_nettype wire

// File: rtl/br_dump_fsm.sv
`default_nettype none
// +------------------------------------------------------------------+
// | br_dump_fsm : sequential register dump sequencer (valid/ready)    |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
module br_dump_fsm
  import br_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int AW    = addr_width(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          ready,
  output logic          valid,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] idx
);

  dump_state_e   state;
  dump_state_e   state_nxt;
  logic [AW-1:0] ptr;
  logic          last;

  assign last = (ptr == AW'(NREGS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= DUMP_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (state == DUMP_IDLE && start) begin
        ptr <= '0;
      end else if (state == DUMP_SCAN && ready && !last) begin
        ptr <= ptr + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    valid     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    idx       = '0;
    case (state)
      DUMP_IDLE: begin
        if (start) state_nxt = DUMP_SCAN;
      end
      DUMP_SCAN: begin
        valid = 1'b1;
        busy  = 1'b1;
        idx   = ptr;
        if (ready && last) state_nxt = DUMP_DONE;
      end
      DUMP_DONE: begin
        done      = 1'b1;
        busy      = 1'b1;
        state_nxt = DUMP_IDLE;
      end
      default: state_nxt = DUMP_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/br_nport.sv
`default_nettype none
// +------------------------------------------------------------------+
// | br_nport : NREGS x XLEN register bank, 1 write / NRD read + dump  |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
module br_nport
  import br_pkg::*;
#(
  parameter int  XLEN     = XLEN_DEFAULT,
  parameter int  NREGS    = 32,
  parameter int  NRD      = 2,
  parameter int  ZERO_REG = 1,
  parameter int  BYPASS   = 1,
  localparam int AW       = addr_width(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we3,
  input  logic [AW-1:0]       wa3,
  input  logic [XLEN-1:0]     wd3,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  input  logic                dump_start,
  output logic                dump_valid,
  input  logic                dump_ready,
  output logic [AW-1:0]       dump_idx,
  output logic [XLEN-1:0]     dump_data,
  output logic                dump_busy,
  output logic                dump_done
);

  logic [XLEN-1:0] mem [NREGS];
  logic            wr_en;
  logic [AW-1:0]   dump_addr;
  rd_sel_e         dump_sel;
  logic [XLEN-1:0] dump_val;

  // A write held during reset or aimed at the zero register never lands, so it is never forwarded.
  assign wr_en = rst_n && we3 && !((ZERO_REG != 0) && (wa3 == '0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wa3] <= wd3;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] addr;
    rd_sel_e       sel;
    assign addr = ra[k*AW +: AW];
    assign sel  = rd_select(ZERO_REG != 0, BYPASS != 0, addr == '0, wr_en && (wa3 == addr));
    assign rd[k*XLEN +: XLEN] = (sel == SEL_ZERO)   ? '0  :
                                (sel == SEL_BYPASS) ? wd3 : mem[addr];
  end

  br_dump_fsm #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_dump (
    .clk   (clk),
    .rst_n (rst_n),
    .start (dump_start),
    .ready (dump_ready),
    .valid (dump_valid),
    .busy  (dump_busy),
    .done  (dump_done),
    .idx   (dump_addr)
  );

  // The dump beat uses the live read path so a stalled beat tracks writes until accepted.
  assign dump_sel  = rd_select(ZERO_REG != 0, BYPASS != 0, dump_addr == '0,
                               wr_en && (wa3 == dump_addr));
  assign dump_val  = (dump_sel == SEL_ZERO)   ? '0  :
                     (dump_sel == SEL_BYPASS) ? wd3 : mem[dump_addr];
  assign dump_data = dump_valid ? dump_val : '0;
  assign dump_idx  = dump_addr;

endmodule
`default_nettype wire

// File: tb/tb_br_nport.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_br_nport : randomized self-checking bench for br_nport         |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_br_nport;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 4;
  localparam int AW    = 5;

  logic                clk;
  logic                rst_n;
  logic                we3;
  logic [AW-1:0]       wa3;
  logic [XLEN-1:0]     wd3;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd;
  logic                dump_start;
  logic                dump_ready;
  logic                dump_valid;
  logic                dump_busy;
  logic                dump_done;
  logic [AW-1:0]       dump_idx;
  logic [XLEN-1:0]     dump_data;

  logic [AW-1:0]       ra_nb;
  logic [XLEN-1:0]     rd_nb;
  logic                nb_valid;
  logic                nb_busy;
  logic                nb_done;
  logic [AW-1:0]       nb_idx;
  logic [XLEN-1:0]     nb_data;

  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0] model [NREGS];

  br_nport #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .we3(we3), .wa3(wa3), .wd3(wd3), .ra(ra), .rd(rd),
    .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_idx(dump_idx), .dump_data(dump_data), .dump_busy(dump_busy), .dump_done(dump_done)
  );

  br_nport #(.XLEN(XLEN), .NREGS(NREGS), .NRD(1), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .we3(we3), .wa3(wa3), .wd3(wd3), .ra(ra_nb), .rd(rd_nb),
    .dump_start(1'b0), .dump_valid(nb_valid), .dump_ready(1'b0),
    .dump_idx(nb_idx), .dump_data(nb_data), .dump_busy(nb_busy), .dump_done(nb_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // Architectural view of a read: zero register, then same-cycle write, then stored value.
  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
    if (a == '0) return '0;
    if (byp && we3 && rst_n && wa3 == a) return wd3;
    return model[a];
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) model[i] = '0;
    end else if (we3 && wa3 != '0) begin
      model[wa3] = wd3;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; we3 = 1'b1; wa3 = 5'd3; wd3 = 32'hDEAD_BEEF;
    dump_start = 1'b1; dump_ready = 1'b1; ra = '0; ra_nb = '0;
    tick();
    tick();
    rst_n = 1'b1; we3 = 1'b0; dump_start = 1'b0;
    for (int a = 0; a < NREGS / NRD; a++) begin
      for (int k = 0; k < NRD; k++) ra[k*AW +: AW] = AW'(a * NRD + k);
      ra_nb = AW'(a * NRD + 1);
      @(negedge clk);
      for (int k = 0; k < NRD; k++) begin
        checks++;
        if (rd[k*XLEN +: XLEN] !== '0) begin
          errors++;
          $display("FAIL reset_rd addr %0d: got %0h expected 0", a * NRD + k, rd[k*XLEN +: XLEN]);
        end
      end
      checks++;
      if (rd_nb !== '0) begin
        errors++;
        $display("FAIL reset_rd_nb: got %0h expected 0", rd_nb);
      end
      checks++;
      if ({dump_valid, dump_busy, dump_done, nb_valid, nb_busy, nb_done} !== 6'b0 ||
          dump_idx !== '0 || dump_data !== '0 || nb_idx !== '0 || nb_data !== '0) begin
        errors++;
        $display("FAIL reset_dump: got v%b b%b d%b idx %0d data %0h expected all 0",
                 dump_valid, dump_busy, dump_done, dump_idx, dump_data);
      end
      tick();
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < NREGS; i++) begin
      we3 = 1'b1; wa3 = AW'(i); wd3 = XLEN'(i);
      ra[0*AW +: AW] = AW'(i);
      ra[1*AW +: AW] = AW'(i - 1);
      ra[2*AW +: AW] = AW'($urandom);
      ra[3*AW +: AW] = AW'($urandom);
      ra_nb = AW'(i);
      @(negedge clk);
      for (int k = 0; k < NRD; k++) begin
        checks++;
        if (rd[k*XLEN +: XLEN] !== exp_rd(ra[k*AW +: AW], 1'b1)) begin
          errors++;
          $display("FAIL fill_rd port %0d: got %0h expected %0h", k, rd[k*XLEN +: XLEN],
                   exp_rd(ra[k*AW +: AW], 1'b1));
        end
      end
      checks++;
      if (rd_nb !== exp_rd(ra_nb, 1'b0)) begin
        errors++;
        $display("FAIL fill_rd_nb: got %0h expected %0h", rd_nb, exp_rd(ra_nb, 1'b0));
      end
      tick();
    end
    we3 = 1'b0;
    for (int i = 1; i < NREGS; i++) begin
      ra[0*AW +: AW] = AW'(i - 1);
      ra[1*AW +: AW] = AW'(i);
      @(negedge clk);
      checks++;
      if (rd[0 +: XLEN] !== XLEN'(i - 1) || rd[XLEN +: XLEN] !== XLEN'(i)) begin
        errors++;
        $display("FAIL fill_pair %0d: got %0h,%0h expected %0h,%0h", i,
                 rd[0 +: XLEN], rd[XLEN +: XLEN], i - 1, i);
      end
      tick();
    end
  endtask

  task automatic test_dump_ready();
    dump_ready = 1'b1; dump_start = 1'b1; we3 = 1'b0;
    tick();
    dump_start = 1'b0;
    for (int c = 1; c <= NREGS + 2; c++) begin
      @(negedge clk);
      if (c <= NREGS) begin
        checks++;
        if (dump_valid !== 1'b1 || dump_busy !== 1'b1 || dump_done !== 1'b0) begin
          errors++;
          $display("FAIL dump_hs cycle %0d: got v%b b%b d%b expected v1 b1 d0",
                   c, dump_valid, dump_busy, dump_done);
        end
        checks++;
        if (dump_idx !== AW'(c - 1) || dump_data !== XLEN'(c - 1)) begin
          errors++;
          $display("FAIL dump_beat cycle %0d: got idx %0d data %0h expected %0d", c,
                   dump_idx, dump_data, c - 1);
        end
      end else if (c == NREGS + 1) begin
        checks++;
        if (dump_done !== 1'b1 || dump_busy !== 1'b1 || dump_valid !== 1'b0) begin
          errors++;
          $display("FAIL dump_done_cycle: got v%b b%b d%b expected v0 b1 d1",
                   dump_valid, dump_busy, dump_done);
        end
      end else begin
        checks++;
        if (dump_done !== 1'b0 || dump_busy !== 1'b0 || dump_valid !== 1'b0) begin
          errors++;
          $display("FAIL dump_idle_after: got v%b b%b d%b expected 0 0 0",
                   dump_valid, dump_busy, dump_done);
        end
      end
      tick();
    end
  endtask

  task automatic test_bypass();
    we3 = 1'b1; wa3 = 5'd5; wd3 = 32'd42;
    ra[0 +: AW] = 5'd5; ra_nb = 5'd5;
    @(negedge clk);
    checks++;
    if (rd[0 +: XLEN] !== 32'd42) begin
      errors++;
      $display("FAIL bypass_same_cycle: got %0d expected 42", rd[0 +: XLEN]);
    end
    checks++;
    if (rd_nb !== 32'd5) begin
      errors++;
      $display("FAIL nobypass_old: got %0d expected 5", rd_nb);
    end
    tick();
    we3 = 1'b0;
    @(negedge clk);
    checks++;
    if (rd_nb !== 32'd42 || rd[0 +: XLEN] !== 32'd42) begin
      errors++;
      $display("FAIL bypass_next_cycle: got %0d,%0d expected 42,42", rd_nb, rd[0 +: XLEN]);
    end
    tick();
  endtask

  task automatic test_multiport();
    we3 = 1'b1; wa3 = 5'd10; wd3 = 32'd99;
    tick();
    we3 = 1'b0;
    ra[0*AW +: AW] = 5'd3;
    ra[1*AW +: AW] = 5'd10;
    ra[2*AW +: AW] = 5'd0;
    ra[3*AW +: AW] = 5'd10;
    @(negedge clk);
    checks++;
    if (rd !== {32'd99, 32'd0, 32'd99, 32'd3}) begin
      errors++;
      $display("FAIL multiport: got %h expected {99,0,99,3}", rd);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int  exp_idx = 0;
    int  dones   = 0;
    int  stall   = 0;
    int  cyc     = 0;
    bit  seen    = 1'b0;
    dump_ready = 1'b0; dump_start = 1'b1; we3 = 1'b0;
    tick();
    dump_start = 1'b0;
    while (!seen && cyc < 500) begin
      cyc++;
      we3 = 1'b0;
      if (exp_idx == 7 && stall < 3) begin
        dump_ready = 1'b0;
        if (stall == 0) begin
          we3 = 1'b1; wa3 = 5'd7; wd3 = 32'd77;
        end
      end else begin
        dump_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 1) == 1) begin
          we3 = 1'b1; wa3 = AW'($urandom_range(8, NREGS - 1)); wd3 = $urandom;
        end
      end
      dump_start = (cyc == 3) || ($urandom_range(0, 3) == 0);
      @(negedge clk);
      if (dump_done) begin
        dones++;
        seen = 1'b1;
        checks++;
        if (exp_idx != NREGS) begin
          errors++;
          $display("FAIL bp_done_early: got %0d beats expected %0d", exp_idx, NREGS);
        end
      end else if (dump_valid) begin
        checks++;
        if (dump_idx !== AW'(exp_idx)) begin
          errors++;
          $display("FAIL bp_idx: got %0d expected %0d", dump_idx, exp_idx);
        end
        checks++;
        if (dump_data !== exp_rd(AW'(exp_idx), 1'b1)) begin
          errors++;
          $display("FAIL bp_data idx %0d: got %0h expected %0h", exp_idx, dump_data,
                   exp_rd(AW'(exp_idx), 1'b1));
        end
        if (exp_idx == 7 && dump_ready) begin
          checks++;
          if (dump_data !== 32'd77) begin
            errors++;
            $display("FAIL bp_idx7_accept: got %0d expected 77", dump_data);
          end
        end
        if (dump_ready) exp_idx++;
        else if (exp_idx == 7) stall++;
      end else begin
        checks++;
        errors++;
        $display("FAIL bp_valid: got idle expected busy at beat %0d", exp_idx);
      end
      tick();
    end
    dump_start = 1'b0; we3 = 1'b0; dump_ready = 1'b1;
    checks++;
    if (!seen || dones != 1) begin
      errors++;
      $display("FAIL bp_single_done: got %0d done pulses expected 1", dones);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (dump_busy !== 1'b0 || dump_valid !== 1'b0 || dump_done !== 1'b0) begin
        errors++;
        $display("FAIL bp_idle: got v%b b%b d%b expected 0 0 0", dump_valid, dump_busy, dump_done);
      end
      tick();
    end
  endtask

  task automatic test_random();
    dump_start = 1'b0;
    for (int n = 0; n < 300; n++) begin
      we3 = 1'($urandom_range(0, 1));
      wa3 = AW'($urandom);
      wd3 = $urandom;
      ra = (NRD*AW)'($urandom);
      if ($urandom_range(0, 3) == 0) ra[0 +: AW] = wa3;
      ra_nb = ($urandom_range(0, 1) == 1) ? wa3 : AW'($urandom);
      @(negedge clk);
      for (int k = 0; k < NRD; k++) begin
        checks++;
        if (rd[k*XLEN +: XLEN] !== exp_rd(ra[k*AW +: AW], 1'b1)) begin
          errors++;
          $display("FAIL rand_rd port %0d addr %0d: got %0h expected %0h", k, ra[k*AW +: AW],
                   rd[k*XLEN +: XLEN], exp_rd(ra[k*AW +: AW], 1'b1));
        end
      end
      checks++;
      if (rd_nb !== exp_rd(ra_nb, 1'b0)) begin
        errors++;
        $display("FAIL rand_rd_nb addr %0d: got %0h expected %0h", ra_nb, rd_nb,
                 exp_rd(ra_nb, 1'b0));
      end
      tick();
    end
    we3 = 1'b0;
  endtask

  task automatic test_reset_mid_dump();
    bit found = 1'b0;
    dump_ready = 1'b1; dump_start = 1'b1; we3 = 1'b0;
    tick();
    dump_start = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (dump_valid && dump_idx == 5'd12) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_reach12: got no beat 12 expected one within 40 cycles");
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int a = 0; a < NREGS / NRD; a++) begin
      for (int k = 0; k < NRD; k++) ra[k*AW +: AW] = AW'(a * NRD + k);
      @(negedge clk);
      checks++;
      if (dump_valid !== 1'b0 || dump_busy !== 1'b0 || dump_done !== 1'b0) begin
        errors++;
        $display("FAIL mid_abort: got v%b b%b d%b expected 0 0 0", dump_valid, dump_busy, dump_done);
      end
      for (int k = 0; k < NRD; k++) begin
        checks++;
        if (rd[k*XLEN +: XLEN] !== '0) begin
          errors++;
          $display("FAIL mid_clear addr %0d: got %0h expected 0", a * NRD + k, rd[k*XLEN +: XLEN]);
        end
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; we3 = 1'b0; wa3 = '0; wd3 = '0; ra = '0; ra_nb = '0;
    dump_start = 1'b0; dump_ready = 1'b0;
    for (int i = 0; i < NREGS; i++) model[i] = '0;
    test_reset();
    test_fill();
    test_dump_ready();
    test_bypass();
    test_multiport();
    test_backpressure();
    test_random();
    test_reset_mid_dump();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
